cal_arb: RTL and testbench

CAL_ARB -- requirements
Module: cal_arb

---
 rtl/cal_arb_pkg.sv | 43 ++++
 rtl/cal_arb.sv | 162 ++++++++++++++++
 tb/tb_cal_arb.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cal_arb_pkg.sv
// Shared calculator constants.
//   - Grant codes reported on cal_arb.arb_res.
//   - Register addresses of the shared calculator register space.
//   - Source/target selectors, used by the arbiter to remember which
//     master the GAP cycle hands the bus to.
//   - Arbiter FSM state type, plus a helper mapping state -> grant code.
package cal_arb_pkg;

  // Grant codes
  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_CPU  = 2'b01;
  localparam logic [1:0] ARB_ACC  = 2'b10;

  // Calculator register map
  localparam logic [15:0] A_REG   = 16'h0000;
  localparam logic [15:0] B_REG   = 16'h0001;
  localparam logic [15:0] OP_REG  = 16'h0002;
  localparam logic [15:0] R_REG   = 16'h0003;
  localparam logic [15:0] S_REG   = 16'h0004;

  // Bus source/target selector
  typedef enum logic {
    TGT_CPU = 1'b0,
    TGT_ACC = 1'b1
  } tgt_e;

  // Arbiter states
  typedef enum logic [1:0] {
    PARK_CPU = 2'd0,
    CPU_OWN  = 2'd1,
    GAP      = 2'd2,
    ACC_OWN  = 2'd3
  } arb_state_e;

  function automatic logic [1:0] state_to_res(input arb_state_e s);
    case (s)
      PARK_CPU, CPU_OWN: state_to_res = ARB_CPU;
      ACC_OWN:           state_to_res = ARB_ACC;
      default:           state_to_res = ARB_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cal_arb.sv
// cal_arb: two-master arbiter for the shared calculator bus.
// The CPU is the default owner: the grant parks on it when nobody asks.
// The accelerator gets the bus only when the CPU is idle, and every owner
// change goes through a one-cycle GAP with the bus driven to zero. While the
// accelerator owns the bus and the CPU is waiting, acc_preempt is raised once
// TENURE cycles have been used. The accelerator is expected to end its burst
// in response.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   cpu_req/addr/wdata/write  CPU master request side
//   acc_req/addr/wdata/write  accelerator master request side
//   bus_rdata               read data from the shared space
//   arb_res                 registered grant code (ARB_IDLE/ARB_CPU/ARB_ACC)
//   bus_addr/wdata/write    muxed bus toward the shared space
//   cpu_rdata, acc_rdata    bus_rdata routed to the current owner, else 0
//   acc_preempt             registered request to end the accelerator burst
//
// TENURE: legal range 1..255.
module cal_arb
  import cal_arb_pkg::*;
#(
  parameter int unsigned TENURE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  input  logic        acc_req,
  input  logic [15:0] acc_addr,
  input  logic [7:0]  acc_wdata,
  input  logic        acc_write,
  input  logic [7:0]  bus_rdata,
  output logic [1:0]  arb_res,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_write,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  acc_rdata,
  output logic        acc_preempt
);

  localparam logic [7:0] TENURE_M1 = 8'(TENURE - 1);

  arb_state_e state_q, state_d;
  tgt_e       tgt_q, tgt_d;
  logic [7:0] ten_cnt_q, ten_cnt_d;
  logic       acc_preempt_q, acc_preempt_d;
  logic [1:0] arb_res_q, arb_res_d;

  logic cpu_busy;
  assign cpu_busy = cpu_req | cpu_write;

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    tgt_d         = tgt_q;
    ten_cnt_d     = '0;
    acc_preempt_d = acc_preempt_q;

    case (state_q)
      PARK_CPU: begin
        if (cpu_busy) begin
          state_d = CPU_OWN;
        end else if (acc_req) begin
          state_d = GAP;
          tgt_d   = TGT_ACC;
        end
      end

      CPU_OWN: begin
        if (!cpu_busy) begin
          if (acc_req) begin
            state_d = GAP;
            tgt_d   = TGT_ACC;
          end else begin
            state_d = PARK_CPU;
          end
        end
      end

      GAP: begin
        state_d       = (tgt_q == TGT_ACC) ? ACC_OWN : PARK_CPU;
        acc_preempt_d = 1'b0;
      end

      ACC_OWN: begin
        if (!acc_req) begin
          // Burst over: a drop here wins over a preempt due this same cycle.
          state_d       = GAP;
          tgt_d         = TGT_CPU;
          acc_preempt_d = 1'b0;
        end else begin
          ten_cnt_d = (ten_cnt_q == 8'hFF) ? 8'hFF : ten_cnt_q + 8'd1;
          // Sticky until the accelerator releases the bus.
          if (cpu_req && (ten_cnt_q >= TENURE_M1)) begin
            acc_preempt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = PARK_CPU;
      end
    endcase

    // The grant code is registered alongside the state it reflects.
    arb_res_d = state_to_res(state_d);
  end

  // State registers
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would make results depend on statement order.
    if (!rst_n) begin
      state_q       <= PARK_CPU;
      tgt_q         <= TGT_CPU;
      ten_cnt_q     <= '0;
      acc_preempt_q <= 1'b0;
      arb_res_q     <= ARB_CPU;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      ten_cnt_q     <= ten_cnt_d;
      acc_preempt_q <= acc_preempt_d;
      arb_res_q     <= arb_res_d;
    end
  end

  // Bus mux, combinational from the registered grant. A non-owner strobe
  // never reaches the bus.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_write = 1'b0;
    cpu_rdata = '0;
    acc_rdata = '0;
    case (arb_res_q)
      ARB_CPU: begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_write = cpu_write;
        cpu_rdata = bus_rdata;
      end
      ARB_ACC: begin
        bus_addr  = acc_addr;
        bus_wdata = acc_wdata;
        bus_write = acc_write;
        acc_rdata = bus_rdata;
      end
      default: ;
    endcase
  end

  assign arb_res     = arb_res_q;
  assign acc_preempt = acc_preempt_q;

endmodule

// File: tb/tb_cal_arb.sv
// Directed testbench for cal_arb (TENURE = 4).
module tb_cal_arb;
  import cal_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_write, acc_req, acc_write;
  logic [15:0] cpu_addr, acc_addr, bus_addr;
  logic [7:0]  cpu_wdata, acc_wdata, bus_rdata, bus_wdata, cpu_rdata, acc_rdata;
  logic [1:0]  arb_res;
  logic        bus_write, acc_preempt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cal_arb #(.TENURE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_write  (cpu_write),
    .acc_req    (acc_req),
    .acc_addr   (acc_addr),
    .acc_wdata  (acc_wdata),
    .acc_write  (acc_write),
    .bus_rdata  (bus_rdata),
    .arb_res    (arb_res),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_write  (bus_write),
    .cpu_rdata  (cpu_rdata),
    .acc_rdata  (acc_rdata),
    .acc_preempt(acc_preempt)
  );

  // Advance one clock; outputs are looked at 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if (arb_res !== ARB_CPU) begin
      miscompares++; $display("FAIL reset_arb_res: got %0h want %0h", arb_res, ARB_CPU);
    end
    vectors++;
    if (acc_preempt !== 1'b0) begin
      miscompares++; $display("FAIL reset_preempt: got %0b want 0", acc_preempt);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (arb_res !== ARB_CPU) begin
      miscompares++; $display("FAIL release_arb_res: got %0h want %0h", arb_res, ARB_CPU);
    end
    // CPU write to S_REG visible the same cycle while parked.
    cpu_addr = S_REG; cpu_wdata = 8'h80; cpu_write = 1'b1;
    #1;
    vectors++;
    if (bus_addr !== S_REG || bus_wdata !== 8'h80 || bus_write !== 1'b1) begin
      miscompares++;
      $display("FAIL park_cpu_write: got addr=%h data=%h wr=%b want addr=%h data=80 wr=1",
               bus_addr, bus_wdata, bus_write, S_REG);
    end
    cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    tick();
  endtask

  task automatic test_acc_grant();
    acc_req = 1'b1; acc_write = 1'b1; acc_addr = 16'h1234; acc_wdata = 8'hC3;
    #1;
    vectors++;
    if (bus_write !== 1'b0 || bus_addr !== 16'h0000) begin
      miscompares++; $display("FAIL acc_req_cycle_bus: got addr=%h wr=%b want addr=0000 wr=0", bus_addr, bus_write);
    end
    tick();
    vectors++;
    if (arb_res !== ARB_IDLE) begin
      miscompares++; $display("FAIL acc_gap_arb_res: got %0h want %0h", arb_res, ARB_IDLE);
    end
    vectors++;
    if (bus_write !== 1'b0 || bus_addr !== 16'h0000 || bus_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL acc_gap_bus: got addr=%h data=%h wr=%b want all zero", bus_addr, bus_wdata, bus_write);
    end
    tick();
    bus_rdata = 8'h5A;
    #1;
    vectors++;
    if (arb_res !== ARB_ACC) begin
      miscompares++; $display("FAIL acc_own_arb_res: got %0h want %0h", arb_res, ARB_ACC);
    end
    vectors++;
    if (bus_write !== 1'b1 || bus_addr !== 16'h1234 || bus_wdata !== 8'hC3) begin
      miscompares++;
      $display("FAIL acc_own_bus: got addr=%h data=%h wr=%b want addr=1234 data=c3 wr=1", bus_addr, bus_wdata, bus_write);
    end
    vectors++;
    if (acc_rdata !== 8'h5A || cpu_rdata !== 8'h00) begin
      miscompares++; $display("FAIL acc_own_rdata: got acc=%h cpu=%h want acc=5a cpu=00", acc_rdata, cpu_rdata);
    end
    acc_req = 1'b0; acc_write = 1'b0; bus_rdata = 8'h00;
    tick();
    vectors++;
    if (arb_res !== ARB_IDLE) begin
      miscompares++; $display("FAIL acc_release_gap: got %0h want %0h", arb_res, ARB_IDLE);
    end
    tick();
    vectors++;
    if (arb_res !== ARB_CPU) begin
      miscompares++; $display("FAIL acc_release_park: got %0h want %0h", arb_res, ARB_CPU);
    end
  endtask

  task automatic test_simultaneous();
    cpu_req = 1'b1; acc_req = 1'b1;
    tick();
    vectors++;
    if (arb_res !== ARB_CPU) begin
      miscompares++; $display("FAIL simul_first: got %0h want %0h", arb_res, ARB_CPU);
    end
    tick();
    vectors++;
    if (arb_res !== ARB_CPU) begin
      miscompares++; $display("FAIL simul_hold: got %0h want %0h", arb_res, ARB_CPU);
    end
    cpu_req = 1'b0;
    tick();
    vectors++;
    if (arb_res !== ARB_IDLE) begin
      miscompares++; $display("FAIL simul_gap: got %0h want %0h", arb_res, ARB_IDLE);
    end
    tick();
    vectors++;
    if (arb_res !== ARB_ACC) begin
      miscompares++; $display("FAIL simul_acc: got %0h want %0h", arb_res, ARB_ACC);
    end
    acc_req = 1'b0;
    tick(); tick();
    vectors++;
    if (arb_res !== ARB_CPU) begin
      miscompares++; $display("FAIL simul_back_to_cpu: got %0h want %0h", arb_res, ARB_CPU);
    end
  endtask

  task automatic test_preempt();
    acc_req = 1'b1;
    tick(); tick();                 // GAP, then 1st owned cycle
    cpu_req = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      vectors++;
      if (acc_preempt !== 1'b0 || arb_res !== ARB_ACC) begin
        miscompares++;
        $display("FAIL preempt_early_%0d: got pre=%b res=%0h want pre=0 res=%0h", i, acc_preempt, arb_res, ARB_ACC);
      end
    end
    tick();
    vectors++;
    if (acc_preempt !== 1'b1 || arb_res !== ARB_ACC) begin
      miscompares++;
      $display("FAIL preempt_assert: got pre=%b res=%0h want pre=1 res=%0h", acc_preempt, arb_res, ARB_ACC);
    end
    tick();
    vectors++;
    if (acc_preempt !== 1'b1 || arb_res !== ARB_ACC) begin
      miscompares++;
      $display("FAIL preempt_hold: got pre=%b res=%0h want pre=1 res=%0h", acc_preempt, arb_res, ARB_ACC);
    end
    acc_req = 1'b0;
    tick();
    vectors++;
    if (acc_preempt !== 1'b0 || arb_res !== ARB_IDLE) begin
      miscompares++;
      $display("FAIL preempt_gap: got pre=%b res=%0h want pre=0 res=%0h", acc_preempt, arb_res, ARB_IDLE);
    end
    tick();
    vectors++;
    if (arb_res !== ARB_CPU) begin
      miscompares++; $display("FAIL preempt_to_cpu: got %0h want %0h", arb_res, ARB_CPU);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_drop_precedence();
    acc_req = 1'b1;
    tick(); tick(); tick(); tick(); tick();   // owned, counter now 3
    vectors++;
    if (arb_res !== ARB_ACC || acc_preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_setup: got res=%0h pre=%b want res=%0h pre=0", arb_res, acc_preempt, ARB_ACC);
    end
    cpu_req = 1'b1; acc_req = 1'b0;
    tick();
    vectors++;
    if (acc_preempt !== 1'b0 || arb_res !== ARB_IDLE) begin
      miscompares++;
      $display("FAIL drop_wins: got pre=%b res=%0h want pre=0 res=%0h", acc_preempt, arb_res, ARB_IDLE);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    acc_req = 1'b1;
    tick(); tick();
    cpu_req = 1'b1;
    tick(); tick(); tick(); tick();
    vectors++;
    if (acc_preempt !== 1'b1) begin
      miscompares++; $display("FAIL rst_setup_preempt: got %0b want 1", acc_preempt);
    end
    acc_write = 1'b1; acc_addr = 16'hBEEF; cpu_write = 1'b0; cpu_addr = A_REG;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (arb_res !== ARB_CPU || acc_preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_burst: got res=%0h pre=%b want res=%0h pre=0", arb_res, acc_preempt, ARB_CPU);
    end
    vectors++;
    if (bus_write !== 1'b0 || bus_addr !== A_REG) begin
      miscompares++; $display("FAIL rst_bus_cpu_off: got wr=%b addr=%h want wr=0 addr=%h", bus_write, bus_addr, A_REG);
    end
    cpu_write = 1'b1;
    #1;
    vectors++;
    if (bus_write !== 1'b1) begin
      miscompares++; $display("FAIL rst_bus_cpu_on: got wr=%b want 1", bus_write);
    end
    cpu_req = 1'b0; cpu_write = 1'b0; acc_req = 1'b0; acc_write = 1'b0;
    tick();
  endtask

  task automatic test_nonowner_write();
    acc_write = 1'b1; acc_addr = 16'h4321; cpu_write = 1'b0; cpu_addr = OP_REG;
    #1;
    vectors++;
    if (bus_write !== 1'b0) begin
      miscompares++; $display("FAIL nonowner_park: got wr=%b want 0", bus_write);
    end
    cpu_write = 1'b1; bus_rdata = 8'h5A;
    #1;
    vectors++;
    if (bus_write !== 1'b1 || bus_addr !== OP_REG) begin
      miscompares++; $display("FAIL owner_write: got wr=%b addr=%h want wr=1 addr=%h", bus_write, bus_addr, OP_REG);
    end
    vectors++;
    if (cpu_rdata !== 8'h5A || acc_rdata !== 8'h00) begin
      miscompares++; $display("FAIL cpu_rdata_route: got cpu=%h acc=%h want cpu=5a acc=00", cpu_rdata, acc_rdata);
    end
    cpu_req = 1'b1;
    tick();                           // CPU_OWN
    cpu_write = 1'b0;
    #1;
    vectors++;
    if (bus_write !== 1'b0 || arb_res !== ARB_CPU) begin
      miscompares++;
      $display("FAIL nonowner_cpu_own: got wr=%b res=%0h want wr=0 res=%0h", bus_write, arb_res, ARB_CPU);
    end
    cpu_req = 1'b0; acc_write = 1'b0; bus_rdata = 8'h00;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    acc_req = 1'b0; acc_write = 1'b0; acc_addr = '0; acc_wdata = '0;
    bus_rdata = '0;
    test_reset();
    test_acc_grant();
    test_simultaneous();
    test_preempt();
    test_drop_precedence();
    test_reset_mid_burst();
    test_nonowner_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
